// File: rtl/anspwm_pkg.sv
// Shared types and constants for the ANS-PWM stage sequencer.
package anspwm_pkg;

    localparam int SAMPLE_W = 16;
    localparam logic [SAMPLE_W-1:0] IDLE_VALUE_DEFAULT = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } seq_state_t;

endpackage

// File: rtl/anspwm_stage_sequencer_if.sv
// Sample handshake into the stage sequencer.
interface anspwm_stage_sequencer_if;
    import anspwm_pkg::*;

    logic [SAMPLE_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/anspwm_frame_timer.sv
// Frame and repetition counters; flags frame wrap and sample fetch point.
module anspwm_frame_timer #(
    parameter int OSR       = 64,
    parameter int FRAME_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic frame_start,
    output logic fetch_point
);

    localparam int FW = $clog2(FRAME_LEN);
    localparam int RW = (OSR > 1) ? $clog2(OSR) : 1;

    logic [FW-1:0] frame_cnt;
    logic [RW-1:0] rep_cnt;
    logic          frame_last;
    logic          rep_last;

    assign frame_last  = frame_cnt == FW'(FRAME_LEN - 1);
    assign rep_last    = rep_cnt == RW'(OSR - 1);
    // frame_start marks the wrap cycle; the strobe itself is registered
    assign frame_start = run && frame_last;
    assign fetch_point = frame_start && rep_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            frame_cnt <= '0;
            rep_cnt   <= '0;
        end else if (run) begin
            if (frame_last) begin
                frame_cnt <= '0;
                rep_cnt   <= rep_last ? '0 : rep_cnt + RW'(1);
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

endmodule

// File: rtl/anspwm_stage_sequencer.sv
// Holds each input sample for OSR frames, strobes the stage chain and
// tracks fill, underrun and graceful stop.
module anspwm_stage_sequencer
    import anspwm_pkg::*;
#(
    parameter int OSR       = 64,
    parameter int FRAME_LEN = 16,
    parameter int LATENCY   = 4,
    parameter logic [SAMPLE_W-1:0] IDLE_VALUE = IDLE_VALUE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clr_stats,
    anspwm_stage_sequencer_if.slave src,
    output logic [SAMPLE_W-1:0] stage_A,
    output logic                stage_en,
    output logic                out_valid,
    output logic [15:0]         underrun_cnt,
    output logic [1:0]          state
);

    localparam int LW = $clog2(LATENCY + 1);

    seq_state_t          cur;
    seq_state_t          nxt;
    logic [LW-1:0]       fill_cnt;
    logic [LW-1:0]       fill_nxt;
    logic [SAMPLE_W-1:0] a_nxt;
    logic                en_nxt;
    logic                ov_nxt;
    logic [15:0]         ur_nxt;

    logic run;
    logic frame_start;
    logic fetch;
    logic xfer;
    logic stop;
    logic underrun;

    assign run         = cur != ST_IDLE;
    assign src.s_ready = !rst && enable && (!run || fetch);
    assign xfer        = src.s_valid && src.s_ready;
    assign stop        = fetch && !enable;
    assign underrun    = fetch && enable && !src.s_valid;
    assign state       = cur;

    anspwm_frame_timer #(
        .OSR       (OSR),
        .FRAME_LEN (FRAME_LEN)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .clr         (stop),
        .frame_start (frame_start),
        .fetch_point (fetch)
    );

    always_comb begin
        nxt      = cur;
        a_nxt    = stage_A;
        en_nxt   = 1'b0;
        ov_nxt   = out_valid;
        fill_nxt = fill_cnt;
        unique case (cur)
            ST_IDLE: begin
                if (xfer) begin
                    nxt      = ST_FILL;
                    a_nxt    = src.s_data;
                    en_nxt   = 1'b1;
                    fill_nxt = '0;
                end
            end
            ST_FILL: begin
                en_nxt = frame_start;
                if (xfer) a_nxt = src.s_data;
                if (stage_en) begin
                    fill_nxt = fill_cnt + LW'(1);
                    if (fill_cnt == LW'(LATENCY - 1)) begin
                        nxt    = ST_RUN;
                        ov_nxt = 1'b1;
                    end
                end
            end
            ST_RUN, ST_HOLD: begin
                en_nxt = frame_start;
                if (xfer) begin
                    a_nxt = src.s_data;
                    nxt   = ST_RUN;
                end else if (underrun) begin
                    nxt = ST_HOLD;
                end
            end
        endcase
        // a stop request only takes effect on a sample boundary
        if (stop) begin
            nxt      = ST_IDLE;
            a_nxt    = IDLE_VALUE;
            en_nxt   = 1'b0;
            ov_nxt   = 1'b0;
            fill_nxt = '0;
        end
    end

    always_comb begin
        ur_nxt = underrun_cnt;
        if (clr_stats) begin
            ur_nxt = '0;
        end else if (underrun && underrun_cnt != 16'hFFFF) begin
            ur_nxt = underrun_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= ST_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_A      <= IDLE_VALUE;
            stage_en     <= 1'b0;
            out_valid    <= 1'b0;
            fill_cnt     <= '0;
            underrun_cnt <= '0;
        end else begin
            stage_A      <= a_nxt;
            stage_en     <= en_nxt;
            out_valid    <= ov_nxt;
            fill_cnt     <= fill_nxt;
            underrun_cnt <= ur_nxt;
        end
    end

endmodule

// File: doc/anspwm_stage_sequencer.md
Name: anspwm_stage_sequencer

Overview:
- Sequences the ANS-PWM noise-shaping stage chain (the cascaded quantize/delayed-diff stages).
- Accepts 16-bit input samples over a valid/ready handshake and holds each sample on the chain input for OSR PWM frames.
- Issues a one-clock stage enable at every frame start and tracks pipeline fill so downstream output is flagged valid only after the chain has settled.
- Handles underrun, where no sample is available at a fetch point, by holding the last value and counting the event.

Parameters:
- OSR, 64: PWM frames per input sample; must be >= 1.
- FRAME_LEN, 16: clocks per PWM frame; must be >= 2.
- LATENCY, 4: stage_en strobes the chain needs before its output is valid; must be >= 1.
- IDLE_VALUE, 16'h8000: mid-scale value driven on stage_A while idle.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request; sampled every clock.
- clr_stats  in  1  clears underrun_cnt.
- s_data  in  16  input sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  sequencer accepts s_data this cycle.
- stage_A  out  16  registered target driven into the first stage.
- stage_en  out  1  one-clock strobe at each frame start.
- out_valid  out  1  chain output is meaningful.
- underrun_cnt  out  16  saturating count of missed fetches.
- state  out  2  IDLE=0, FILL=1, RUN=2, HOLD=3.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, stage_A=IDLE_VALUE.
  - stage_en=0, out_valid=0, underrun_cnt=0.
  - frame_cnt=0, rep_cnt=0, fill_cnt=0.
  - s_ready=0 for the whole reset cycle.
- Counters:
  - frame_cnt runs 0..FRAME_LEN-1 and wraps.
  - rep_cnt increments when frame_cnt wraps and runs 0..OSR-1.
  - Both counters run only in FILL, RUN and HOLD; they are held at 0 in IDLE.
- Fetch point: frame_cnt==FRAME_LEN-1 and rep_cnt==OSR-1 in FILL, RUN or HOLD.
- s_ready is combinational and never registered:
  - 1 in IDLE when enable=1.
  - 1 at a fetch point when enable=1.
  - 0 otherwise.
- Transfer occurs on s_valid and s_ready in the same cycle. On a transfer at cycle t, stage_A=s_data from t+1.
- stage_en=1 in the cycle after frame_cnt wraps (frame_cnt==0), and in the cycle after the IDLE->FILL transfer. It is high for exactly one clock per frame.
- IDLE:
  - transfer -> FILL; frame_cnt=rep_cnt=fill_cnt=0 at t+1, stage_en=1 at t+1.
  - Without a transfer, outputs stay at their idle values.
- FILL:
  - fill_cnt increments on each stage_en.
  - When the LATENCY-th strobe is issued, out_valid=1 from the next cycle and the state becomes RUN.
  - A fetch-point underrun in FILL holds stage_A, counts the underrun, and fill continues.
- RUN:
  - Fetch with transfer -> stay in RUN.
  - Fetch with enable=1 and s_valid=0 -> HOLD; stage_A is held, underrun_cnt+1.
- HOLD:
  - out_valid stays 1; stage_A is held.
  - The next fetch with transfer -> RUN.
  - A further miss increments underrun_cnt again and stays in HOLD.
- enable=0 at a fetch point, from any non-IDLE state:
  - -> IDLE at the next cycle: out_valid=0, stage_A=IDLE_VALUE, counters cleared.
  - No transfer occurs even if s_valid=1.
  - This is not counted as an underrun.
  - enable=0 away from a fetch point has no effect until the fetch point (graceful stop).
- underrun_cnt saturates at 16'hFFFF. If clr_stats and an underrun occur in the same cycle, clear wins and the result is 0.
- Reset mid-operation returns everything to the reset values above on the next edge, regardless of state. A pending s_valid is not consumed.
- All outputs except s_ready are registered.

Decomposition:
- Package anspwm_pkg:
  - seq_state_t enum (IDLE, FILL, RUN, HOLD as 2-bit values).
  - IDLE_VALUE_DEFAULT constant.
  - SAMPLE_W=16 constant.
- Sub-module anspwm_frame_timer: frame_cnt/rep_cnt with run and clear inputs, producing frame_start and fetch_point outputs.
- The FSM, handshake and statistics stay in the top level.

Test Plan (bench parameters OSR=4, FRAME_LEN=8, LATENCY=3):
- Reset then idle: rst for 2 clks, enable=0, s_valid=1 -> s_ready=0, stage_A=16'h8000, stage_en never asserted, state=0.
- Start and fill: enable=1, s_data=16'h1234 accepted at t -> stage_A=16'h1234 and stage_en at t+1, further strobes at t+9 and t+17, out_valid=1 at t+18, state=2.
- Steady stream: s_valid held high with incrementing data -> exactly one transfer per 32 clks, each sample present for 4 stage_en strobes, underrun_cnt=0.
- Underrun/recovery: drop s_valid at one fetch point -> state=3, stage_A unchanged, underrun_cnt=1, out_valid stays 1. Restore s_valid -> state=2 at the next fetch with new data.
- Graceful stop: enable=0 in mid-frame -> continues until the fetch point, then state=0, out_valid=0, stage_A=16'h8000, no data consumed.
- Stats corner: force 65536 underruns -> underrun_cnt stays 16'hFFFF. Assert clr_stats in an underrun cycle -> 0. Assert rst in RUN -> all reset values on the next clk.
